// File: rtl/zfifo_sync_pkg.sv
// Shared FIFO definitions: pointer/count width helpers and the registered
// status-flag bundle with its reset value, reusable by other FIFO wrappers.
package zfifo_sync_pkg;

   // Pointer width for a power-of-two depth.
   function automatic int ptr_width(input int depth);
      return $clog2(depth);
   endfunction

   // Occupancy counters need one extra bit so that "exactly full" is representable.
   function automatic int cnt_width(input int ptr_w);
      return ptr_w + 1;
   endfunction

   // Registered status flags carried as one bundle.
   typedef struct packed {
      logic full;
      logic afull;
      logic empty;
      logic drop;
   } fifo_flags_t;

   // Flag values while in reset: an empty FIFO that has refused nothing.
   localparam fifo_flags_t FIFO_FLAGS_RST = '{full: 1'b0, afull: 1'b0, empty: 1'b1, drop: 1'b0};

endpackage : zfifo_sync_pkg

// File: rtl/zfifo_dualport.sv
// Simple dual-port RAM: one synchronous write port and one registered read
// port. No read/write collision handling; the controller must avoid reading
// the address being written in the same cycle. Contents are never cleared.
module zfifo_dualport #(
   parameter int depth      = 64,
   parameter int log2_depth = 6,
   parameter int width      = 8
) (
   input  logic                  iClk,
   input  logic                  iWrEn,
   input  logic [log2_depth-1:0] iWrAddr,
   input  logic [width-1:0]      iWrData,
   input  logic                  iRdEn,
   input  logic [log2_depth-1:0] iRdAddr,
   output logic [width-1:0]      oRdData
);

   logic [width-1:0] mem [depth];
   logic [width-1:0] rd_data_q;

   // Write port: store the word on an enabled write.
   always_ff @(posedge iClk) begin
      if (iWrEn) begin
         mem[iWrAddr] <= iWrData;
      end
   end

   // Read port: output register only updates on an issued read, otherwise holds.
   always_ff @(posedge iClk) begin
      if (iRdEn) begin
         rd_data_q <= mem[iRdAddr];
      end
   end

   assign oRdData = rd_data_q;

endmodule : zfifo_dualport

// File: rtl/zfifo_sync.sv
// Single-clock FIFO controller around zfifo_dualport. Push port on one side,
// first-word-fall-through valid/ready pop port on the other. The RAM output
// register acts as the head slot, so total capacity is depth+1 words.
module zfifo_sync
   import zfifo_sync_pkg::*;
#(
   parameter int depth      = 64,
   parameter int log2_depth = 6,
   parameter int width      = 8,
   parameter int afull_th   = 56
) (
   input  logic                  iClk,
   input  logic                  iRstN,
   input  logic                  iWrEn,
   input  logic [width-1:0]      iWrData,
   output logic                  oFull,
   output logic                  oAlmostFull,
   output logic                  oWrDrop,
   output logic [width-1:0]      oRdData,
   output logic                  oRdValid,
   input  logic                  iRdReady,
   output logic                  oEmpty,
   output logic [log2_depth:0]   oLevel
);

   localparam int              CW      = cnt_width(log2_depth);
   localparam logic [CW-1:0]   DEPTH_C = CW'(depth);
   localparam logic [CW-1:0]   AFULL_C = CW'(afull_th);
   localparam logic [log2_depth-1:0] PTR_ONE = log2_depth'(1);

   logic [log2_depth-1:0] wr_ptr_q, wr_ptr_d;
   logic [log2_depth-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]         ram_cnt_q, ram_cnt_d;
   logic [CW-1:0]         level_q, level_d;
   logic                  rd_valid_q, rd_valid_d;
   fifo_flags_t           flags_q, flags_d;
   logic                  wr_acc;
   logic                  rd_issue;

   // Next-state: accept/refuse pushes, issue prefetch reads, derive flags from next counts.
   always_comb begin
      // oFull is registered, so a push is refused even when a pop frees a slot this cycle.
      wr_acc   = iWrEn && !flags_q.full;
      // Only the registered count is consulted: a word written this cycle is not
      // visible to the read side until next cycle, so read and write never collide.
      rd_issue = (ram_cnt_q != '0) && (!rd_valid_q || iRdReady);

      wr_ptr_d   = wr_acc   ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
      rd_ptr_d   = rd_issue ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
      ram_cnt_d  = ram_cnt_q + {{(CW-1){1'b0}}, wr_acc} - {{(CW-1){1'b0}}, rd_issue};
      rd_valid_d = rd_issue || (rd_valid_q && !iRdReady);

      flags_d.full  = (ram_cnt_d == DEPTH_C);
      flags_d.afull = (ram_cnt_d >= AFULL_C);
      flags_d.empty = (ram_cnt_d == '0) && !rd_valid_d;
      flags_d.drop  = iWrEn && flags_q.full;
      level_d       = ram_cnt_d + {{(CW-1){1'b0}}, rd_valid_d};
   end

   // State registers with asynchronous active-low clear.
   always_ff @(posedge iClk or negedge iRstN) begin
      if (!iRstN) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         ram_cnt_q  <= '0;
         rd_valid_q <= 1'b0;
         level_q    <= '0;
         flags_q    <= FIFO_FLAGS_RST;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         ram_cnt_q  <= ram_cnt_d;
         rd_valid_q <= rd_valid_d;
         level_q    <= level_d;
         flags_q    <= flags_d;
      end
   end

   zfifo_dualport #(
      .depth      (depth),
      .log2_depth (log2_depth),
      .width      (width)
   ) u_ram (
      .iClk    (iClk),
      .iWrEn   (wr_acc),
      .iWrAddr (wr_ptr_q),
      .iWrData (iWrData),
      .iRdEn   (rd_issue),
      .iRdAddr (rd_ptr_q),
      .oRdData (oRdData)
   );

   assign oFull       = flags_q.full;
   assign oAlmostFull = flags_q.afull;
   assign oWrDrop     = flags_q.drop;
   assign oEmpty      = flags_q.empty;
   assign oRdValid    = rd_valid_q;
   assign oLevel      = level_q;

endmodule : zfifo_sync

// File: doc/zfifo_sync.md
Name: zfifo_sync

Overview:
Synchronous single-clock FIFO controller that drives the existing dual-port RAM block (zfifo_dualport) from both ends. It owns the write and read pointers, occupancy, full/empty flags and prefetch, and exposes a push port plus a first-word-fall-through valid/ready pop port. The RAM has no read/write conflict control, so this block never reads an address that is being written in the same cycle.

Parameters:
depth, 64, RAM words (power of two)
log2_depth, 6, log2(depth); pointer width
width, 8, data word width
afull_th, 56, oAlmostFull asserts when RAM occupancy >= afull_th

Ports:
iClk  in  1  clock, all logic on rising edge
iRstN  in  1  reset, asynchronous assert, active-low
iWrEn  in  1  push request
iWrData  in  width  push data
oFull  out  1  RAM occupancy == depth; a push is ignored while high
oAlmostFull  out  1  RAM occupancy >= afull_th
oWrDrop  out  1  one-cycle pulse, iWrEn seen while oFull
oRdData  out  width  head word, valid when oRdValid
oRdValid  out  1  head word present on oRdData
iRdReady  in  1  consumer accepts head word when oRdValid && iRdReady
oEmpty  out  1  !oRdValid && RAM occupancy == 0
oLevel  out  log2_depth+1  RAM occupancy + oRdValid (total words held)

Behaviour:
- Reset (iRstN low, async): wr_ptr=0, rd_ptr=0, ram_cnt=0, oRdValid=0, oFull=0, oAlmostFull=0, oWrDrop=0, oEmpty=1, oLevel=0. oRdData is unreset (RAM output register); don't-care while oRdValid=0. RAM contents are not cleared.
- Push: wr_acc = iWrEn && !oFull. On wr_acc, RAM write at wr_ptr, wr_ptr += 1 mod depth. On iWrEn && oFull, no write, oWrDrop=1 next cycle.
- Prefetch: rd_issue = (ram_cnt != 0) && (!oRdValid || iRdReady). ram_cnt is the registered value, so a word written this cycle is never read this cycle (no same-address conflict). On rd_issue, RAM read at rd_ptr, rd_ptr += 1 mod depth. oRdValid_next = rd_issue || (oRdValid && !iRdReady).
- Hold: while oRdValid && !iRdReady, no RAM read is issued, so the RAM output register holds oRdData stable.
- ram_cnt_next = ram_cnt + wr_acc - rd_issue. Width is log2_depth+1 and never exceeds depth.
- Flags are registered from next-state values: oFull=(ram_cnt_next==depth), oAlmostFull=(ram_cnt_next>=afull_th), oEmpty=(ram_cnt_next==0 && !oRdValid_next), oLevel=ram_cnt_next+oRdValid_next.
- Latency: push at cycle N into an empty FIFO gives oRdValid=1 with that data at cycle N+2.
- Throughput: 1 push and 1 pop per cycle sustained once oRdValid=1.
- Full plus simultaneous pop: the push is still refused (oFull is registered). The pop frees a slot, and oFull drops on the following cycle.
- Wrap-around: pointers wrap naturally via power-of-two depth. Data order is preserved across the wrap.
- Total capacity is depth+1 words (RAM plus head register).

Decomposition:
- Shared package: pointer/count width derivation (log2_depth, log2_depth+1) and the FIFO flag bundle constants, for reuse by other FIFO wrappers.
- One sub-module: zfifo_dualport instance as the storage. Its iWrEn=wr_acc, iWrAddr=wr_ptr, iRdEn=rd_issue, iRdAddr=rd_ptr, and oRdData maps straight to oRdData.
- Everything else stays flat in zfifo_sync.

Test Plan:
- Reset then idle: oEmpty=1, oRdValid=0, oLevel=0, oFull=0 for 10 cycles. Async-assert iRstN mid-clock and outputs clear immediately, without waiting for an edge.
- Single push 0xA5 at cycle N, iRdReady=1: oRdValid=1 and oRdData=0xA5 at N+2; oEmpty=0 from N+1; oEmpty=1 again after the pop.
- Fill with iRdReady=0, pushing 0..65: oAlmostFull rises when ram_cnt hits 56; oFull=1 at ram_cnt 64; oLevel=65; 66th push gives oWrDrop=1 and no data corruption. Then drain reads 0..64 in order.
- Backpressure: toggle iRdReady pseudo-randomly while pushing 200 incrementing words. oRdData is stable while oRdValid && !iRdReady, and the received sequence is 0..199 with no gaps (covers pointer wrap).
- Full plus simultaneous pop/push: at oFull=1, iRdReady=1 and iWrEn=1 in the same cycle. The push is dropped (oWrDrop=1); the next cycle oFull=0 and the retried push is accepted.
- Streaming: continuous push and iRdReady=1 for 300 cycles. After warm-up, oRdValid stays 1 every cycle, oLevel is steady, and output equals input delayed by 2 cycles.
